// File: rtl/mmv_arb_pkg.sv
// Shared types and helpers for the MMV round-robin arbiter: lock state,
// round-robin search result and parameter range checks.
package mmv_arb_pkg;

    localparam int MIN_PORTS = 2;
    localparam int MAX_PORTS = 16;
    localparam int PW        = 4;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic          found;
        logic [PW-1:0] idx;
    } rr_pick_t;

    function automatic bit nports_ok(input int n);
        return (n >= MIN_PORTS) && (n <= MAX_PORTS);
    endfunction

    function automatic bit depth_ok(input int d);
        return (d >= 2) && ((d & (d - 1)) == 0);
    endfunction

    // First requester at or after ptr, wrapping at nports.
    function automatic rr_pick_t rr_pick(input logic [MAX_PORTS-1:0] req,
                                         input logic [PW-1:0] ptr,
                                         input int nports);
        rr_pick_t r;
        int       p;
        r.found = 1'b0;
        r.idx   = '0;
        for (int k = 0; k < MAX_PORTS; k++) begin
            p = (int'(ptr) + k) % nports;
            if (k < nports && !r.found && req[p]) begin
                r.found = 1'b1;
                r.idx   = PW'(p);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mmv_arb_ofifo.sv
// Order FIFO holding the port index of each outstanding read. A pop on an
// empty FIFO with a simultaneous push passes the pushed entry straight through.
module mmv_arb_ofifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign head    = empty ? push_data : mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // When full, a push is only legal alongside a pop that frees the slot.
    assign do_push = push & ~(empty & pop) & (~full | pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmv_arbiter.sv
// Round-robin arbiter sharing one MMV slave among NPORTS masters; read data is
// steered back to the issuing port in order via the order FIFO.
module mmv_arbiter
    import mmv_arb_pkg::*;
#(
    parameter int NPORTS  = 2,
    parameter int AWIDTH  = 8,
    parameter int DWIDTH  = 8,
    parameter int RDEPTH  = 4,
    localparam int IWIDTH = $clog2(NPORTS),
    localparam int CWIDTH = $clog2(RDEPTH) + 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NPORTS-1:0][AWIDTH-1:0]  s_addr,
    input  logic [NPORTS-1:0]              s_wreq,
    input  logic [NPORTS-1:0][DWIDTH-1:0]  s_wdat,
    input  logic [NPORTS-1:0]              s_rreq,
    output logic [DWIDTH-1:0]              s_rdat,
    output logic [NPORTS-1:0]              s_rval,
    output logic [NPORTS-1:0]              s_busy,
    output logic [AWIDTH-1:0]              m_addr,
    output logic                           m_wreq,
    output logic [DWIDTH-1:0]              m_wdat,
    output logic                           m_rreq,
    input  logic [DWIDTH-1:0]              m_rdat,
    input  logic                           m_rval,
    input  logic                           m_busy,
    output logic                           rerr,
    output logic                           dbg_locked,
    output logic [CWIDTH-1:0]              dbg_ocount
);

    if (!nports_ok(NPORTS) || !depth_ok(RDEPTH)) begin : g_bad_params
        $error("mmv_arbiter: NPORTS must be 2..16 and RDEPTH a power of two >= 2");
    end

    // Handshake: a port holds s_wreq/s_rreq with addr/data until a cycle where
    // s_busy is low; that cycle is the accept. m_* follows the same rule against m_busy.
    logic [NPORTS-1:0] req;
    arb_state_e        state_q, state_d;
    logic [IWIDTH-1:0] ptr_q, ptr_d, gidx_q, gidx_d;
    logic [IWIDTH-1:0] win, sel;
    logic              active, rd_blocked, accept, push;
    rr_pick_t          pick;
    logic              pick_unused;
    logic              ofifo_full, ofifo_empty;
    logic [IWIDTH-1:0] ofifo_head;
    logic              rerr_q;

    assign req         = s_wreq | s_rreq;
    assign pick        = rr_pick(MAX_PORTS'(req), PW'(ptr_q), NPORTS);
    assign pick_unused = ^pick.idx;

    always_comb begin
        win        = '0;
        active     = 1'b0;
        if (state_q == ARB_LOCKED) begin
            win    = gidx_q;
            active = req[gidx_q];
        end else begin
            win    = pick.idx[IWIDTH-1:0];
            active = pick.found;
        end
        // A pop in the same cycle frees a slot, so only a non-popping full FIFO blocks.
        rd_blocked = active & s_rreq[win] & ofifo_full & ~m_rval;
        accept     = reset_n & active & ~m_busy & ~rd_blocked;
        push       = accept & s_rreq[win];
        sel        = active ? win : '0;
        m_addr     = s_addr[sel];
        m_wdat     = s_wdat[sel];
        m_wreq     = reset_n & active & s_wreq[win];
        m_rreq     = reset_n & active & s_rreq[win] & ~rd_blocked;
        for (int i = 0; i < NPORTS; i++) begin
            if (active && IWIDTH'(i) == win) s_busy[i] = reset_n & (m_busy | rd_blocked);
            else                             s_busy[i] = reset_n & req[i];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        if (accept) begin
            state_d = ARB_OPEN;
            ptr_d   = (win == IWIDTH'(NPORTS - 1)) ? '0 : win + 1'b1;
        end else if (active) begin
            state_d = ARB_LOCKED;
            gidx_d  = win;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_OPEN;
            ptr_q   <= '0;
            gidx_q  <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            if (m_rval && ofifo_empty && !push) rerr_q <= 1'b1;
        end
    end

    mmv_arb_ofifo #(
        .DEPTH (RDEPTH),
        .W     (IWIDTH)
    ) u_ofifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (win),
        .pop       (m_rval),
        .head      (ofifo_head),
        .full      (ofifo_full),
        .empty     (ofifo_empty),
        .count     (dbg_ocount)
    );

    always_comb begin
        s_rval = '0;
        if (m_rval && (!ofifo_empty || push)) s_rval[ofifo_head] = 1'b1;
    end

    assign s_rdat     = m_rdat;
    assign rerr       = rerr_q;
    assign dbg_locked = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_mmv_arbiter.sv
// Directed bench for mmv_arbiter with a rule-level reference model checked
// every cycle, a grant-order scoreboard and literal expectations per scenario.
module tb_mmv_arbiter;

    localparam int NP = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int RD = 4;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic [NP-1:0][AW-1:0] s_addr;
    logic [NP-1:0]         s_wreq;
    logic [NP-1:0][DW-1:0] s_wdat;
    logic [NP-1:0]         s_rreq;
    logic [DW-1:0]         s_rdat;
    logic [NP-1:0]         s_rval;
    logic [NP-1:0]         s_busy;
    logic [AW-1:0]         m_addr;
    logic                  m_wreq;
    logic [DW-1:0]         m_wdat;
    logic                  m_rreq;
    logic [DW-1:0]         m_rdat;
    logic                  m_rval;
    logic                  m_busy;
    logic                  rerr;
    logic                  dbg_locked;
    logic [2:0]            dbg_ocount;

    int total = 0;
    int bad   = 0;

    // reference model state
    int   mptr;
    bit   mlock;
    int   mgidx;
    int   oq[$];
    bit   mrerr;

    logic [7:0] exp_q[$];
    bit         mon_en = 1'b0;

    mmv_arbiter #(.NPORTS(NP), .AWIDTH(AW), .DWIDTH(DW), .RDEPTH(RD)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_addr     (s_addr),
        .s_wreq     (s_wreq),
        .s_wdat     (s_wdat),
        .s_rreq     (s_rreq),
        .s_rdat     (s_rdat),
        .s_rval     (s_rval),
        .s_busy     (s_busy),
        .m_addr     (m_addr),
        .m_wreq     (m_wreq),
        .m_wdat     (m_wdat),
        .m_rreq     (m_rreq),
        .m_rdat     (m_rdat),
        .m_rval     (m_rval),
        .m_busy     (m_busy),
        .rerr       (rerr),
        .dbg_locked (dbg_locked),
        .dbg_ocount (dbg_ocount)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Who is served this cycle, whether the read is held off by a full order queue,
    // and whether the transfer is accepted.
    function automatic void model_eval(output int win, output bit act, output bit blk, output bit acc);
        win = 0;
        act = 1'b0;
        if (mlock) begin
            win = mgidx;
            act = s_wreq[win] | s_rreq[win];
        end else begin
            for (int k = 0; k < NP; k++) begin
                int p;
                p = (mptr + k) % NP;
                if (!act && (s_wreq[p] | s_rreq[p])) begin
                    win = p;
                    act = 1'b1;
                end
            end
        end
        blk = act && s_rreq[win] && (oq.size() >= RD) && !m_rval;
        acc = act && !m_busy && !blk;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        int win;
        bit act, blk, acc;
        if (!reset_n) begin
            mptr  = 0;
            mlock = 1'b0;
            mgidx = 0;
            oq.delete();
            mrerr = 1'b0;
        end else begin
            model_eval(win, act, blk, acc);
            if (acc) begin
                mptr  = (win + 1) % NP;
                mlock = 1'b0;
                if (s_rreq[win]) oq.push_back(win);
            end else if (act) begin
                mlock = 1'b1;
                mgidx = win;
            end
            if (m_rval) begin
                if (oq.size() > 0) void'(oq.pop_front());
                else               mrerr = 1'b1;
            end
        end
    end

    // per-cycle compare against the model, plus the grant-order scoreboard
    always @(negedge clk) begin
        int            win;
        bit            act, blk, acc;
        logic [NP-1:0] ebusy, erval;
        logic [7:0]    e;
        if (!reset_n) begin
            chk("rst_m_wreq", m_wreq, 0);
            chk("rst_m_rreq", m_rreq, 0);
            chk("rst_s_busy", s_busy, 0);
            chk("rst_s_rval", s_rval, 0);
            chk("rst_rerr", rerr, 0);
        end else begin
            model_eval(win, act, blk, acc);
            ebusy = '0;
            for (int i = 0; i < NP; i++) begin
                if (s_wreq[i] | s_rreq[i]) ebusy[i] = (act && i == win) ? (m_busy | blk) : 1'b1;
            end
            erval = '0;
            if (m_rval) begin
                if (oq.size() > 0)             erval[oq[0]] = 1'b1;
                else if (acc && s_rreq[win])   erval[win] = 1'b1;
            end
            chk("m_wreq", m_wreq, act & s_wreq[win]);
            chk("m_rreq", m_rreq, act & s_rreq[win] & ~blk);
            chk("m_addr", m_addr, act ? s_addr[win] : s_addr[0]);
            chk("m_wdat", m_wdat, act ? s_wdat[win] : s_wdat[0]);
            chk("s_busy", s_busy, ebusy);
            chk("s_rval", s_rval, erval);
            chk("s_rdat", s_rdat, m_rdat);
            chk("rerr", rerr, mrerr);
            chk("locked", dbg_locked, mlock);
            chk("ocount", dbg_ocount, oq.size());
            if (mon_en && (m_wreq | m_rreq) && !m_busy) begin
                if (exp_q.size() == 0) begin
                    chk("grant_extra", m_addr, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant_order", 8'(m_addr - 8'h40), e);
                end
            end
        end
    end

    initial begin
        s_wreq = '0;
        s_rreq = '0;
        m_rval = 1'b0;
        m_busy = 1'b0;
        m_rdat = '0;
        for (int i = 0; i < NP; i++) begin
            s_addr[i] = 8'(8'h40 + i);
            s_wdat[i] = 8'(8'h80 + i);
        end

        // requests during reset must not reach the slave
        s_wreq = 4'b1111;
        repeat (2) tick();
        chk("lit_rst_busy", s_busy, 4'b0000);
        chk("lit_rst_wreq", m_wreq, 0);
        chk("lit_rst_rerr", rerr, 0);

        // all ports request continuously: 0,1,2,3,0,1,2,3
        reset_n = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NP; i++) exp_q.push_back(8'(i));
        mon_en = 1'b1;
        #1;
        chk("lit_rr_first", m_addr, 8'h40);
        chk("lit_rr_busy", s_busy, 4'b1110);
        #1;
        repeat (8) tick();
        s_wreq = '0;
        mon_en = 1'b0;
        chk("lit_rr_drained", exp_q.size(), 0);

        // single port write
        s_wreq    = 4'b0010;
        s_addr[1] = 8'h10;
        s_wdat[1] = 8'hA5;
        #1;
        chk("lit_w_wreq", m_wreq, 1);
        chk("lit_w_addr", m_addr, 8'h10);
        chk("lit_w_wdat", m_wdat, 8'hA5);
        chk("lit_w_busy", s_busy, 4'b0000);
        tick();

        // slave stall: port 2 holds the grant over port 0
        s_wreq    = 4'b0101;
        s_addr[2] = 8'h20;
        s_addr[0] = 8'h30;
        m_busy    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("lit_stall_addr", m_addr, 8'h20);
            chk("lit_stall_busy", s_busy, 4'b0101);
            tick();
        end
        m_busy = 1'b0;
        #1;
        chk("lit_stall_acc_addr", m_addr, 8'h20);
        chk("lit_stall_acc_busy", s_busy, 4'b0001);
        tick();
        s_wreq = 4'b0001;
        #1;
        chk("lit_stall_next", m_addr, 8'h30);
        chk("lit_stall_next_busy", s_busy, 4'b0000);
        tick();
        s_wreq = '0;

        // in-order read return: port 0 twice, then port 1
        s_rreq    = 4'b0001;
        s_addr[0] = 8'h50;
        #1;
        chk("lit_rd_rreq", m_rreq, 1);
        tick();
        s_addr[0] = 8'h51;
        tick();
        s_rreq    = 4'b0010;
        s_addr[1] = 8'h60;
        tick();
        s_rreq = '0;
        m_rval = 1'b1;
        m_rdat = 8'h11;
        #1;
        chk("lit_rd1_val", s_rval, 4'b0001);
        chk("lit_rd1_dat", s_rdat, 8'h11);
        tick();
        m_rdat = 8'h22;
        #1;
        chk("lit_rd2_val", s_rval, 4'b0001);
        chk("lit_rd2_dat", s_rdat, 8'h22);
        tick();
        m_rdat = 8'h33;
        #1;
        chk("lit_rd3_val", s_rval, 4'b0010);
        chk("lit_rd3_dat", s_rdat, 8'h33);
        tick();
        m_rval = 1'b0;

        // order FIFO full: fifth read stalls until a pop frees a slot
        s_rreq    = 4'b1000;
        s_addr[3] = 8'h70;
        repeat (4) tick();
        s_rreq    = 4'b0100;
        s_addr[2] = 8'h71;
        #1;
        chk("lit_full_busy", s_busy, 4'b0100);
        chk("lit_full_rreq", m_rreq, 0);
        chk("lit_full_cnt", dbg_ocount, 4);
        tick();
        m_rval = 1'b1;
        m_rdat = 8'h44;
        #1;
        chk("lit_full_pop_busy", s_busy, 4'b0000);
        chk("lit_full_pop_rreq", m_rreq, 1);
        chk("lit_full_pop_rval", s_rval, 4'b1000);
        tick();
        s_rreq = '0;
        m_rval = 1'b0;
        #1;
        chk("lit_full_cnt_after", dbg_ocount, 4);
        m_rval = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("lit_drain_rval", s_rval, (c == 3) ? 4'b0100 : 4'b1000);
            tick();
        end
        m_rval = 1'b0;

        // response with nothing outstanding
        m_rval = 1'b1;
        m_rdat = 8'h77;
        #1;
        chk("lit_err_rval", s_rval, 4'b0000);
        chk("lit_err_pre", rerr, 0);
        tick();
        m_rval = 1'b0;
        #1;
        chk("lit_err_set", rerr, 1);
        repeat (3) tick();
        chk("lit_err_hold", rerr, 1);

        // reset in the middle of traffic with a read outstanding
        s_rreq    = 4'b0010;
        s_addr[1] = 8'h61;
        tick();
        s_rreq = 4'b0001;
        #1;
        reset_n = 1'b0;
        #1;
        chk("lit_mrst_rerr", rerr, 0);
        chk("lit_mrst_rreq", m_rreq, 0);
        chk("lit_mrst_busy", s_busy, 4'b0000);
        tick();
        reset_n = 1'b1;
        s_rreq  = '0;
        s_wreq  = 4'b1111;
        for (int i = 0; i < NP; i++) s_addr[i] = 8'(8'h40 + i);
        #1;
        chk("lit_mrst_ptr0", m_addr, 8'h40);
        tick();
        s_wreq = '0;
        m_rval = 1'b1;
        #1;
        chk("lit_mrst_drop_rval", s_rval, 4'b0000);
        tick();
        m_rval = 1'b0;
        #1;
        chk("lit_mrst_drop_rerr", rerr, 1);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
